// File: rtl/top_if.sv
// ============================================================================
// Module   : top_if
// Purpose  : MIPS instruction-fetch stage: PC, program memory, IF/ID register.
//            Optional macro IF_BRANCH_FLUSH_EN replaces the delay slot by a NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_if #(
    parameter int                            LENGTH_INSTRUCTION = 32,
    parameter int                            CANT_BITS_ADDR     = 11,
    parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION   = 32'hFFFFFFFF
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_enable_pipeline,
    input  logic                          i_stall,
    input  logic                          i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
    input  logic                          i_write_mem_enable,
    input  logic [CANT_BITS_ADDR-1:0]     i_addr_mem_write,
    input  logic [LENGTH_INSTRUCTION-1:0] i_data_mem_write,
    output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
    output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
    output logic [CANT_BITS_ADDR-1:0]     o_pc,
    output logic                          o_halt_fetched
);

    localparam int c_DEPTH = 2 ** CANT_BITS_ADDR;

    logic [LENGTH_INSTRUCTION-1:0] r_mem [c_DEPTH];
    logic [CANT_BITS_ADDR-1:0]     r_pc;
    logic [LENGTH_INSTRUCTION-1:0] r_instruction;
    logic [CANT_BITS_ADDR-1:0]     r_out_adder_pc;
    logic                          r_halt_fetched;

    logic [LENGTH_INSTRUCTION-1:0] w_fetched;
    logic [LENGTH_INSTRUCTION-1:0] w_next_instruction;
    logic [CANT_BITS_ADDR-1:0]     w_pc_plus1;
    logic                          w_advance;
    logic                          w_is_halt;

    assign w_fetched  = r_mem[r_pc];
    assign w_pc_plus1 = r_pc + CANT_BITS_ADDR'(1);
    assign w_advance  = i_enable_pipeline & ~i_stall & ~r_halt_fetched;
    assign w_is_halt  = (w_fetched == HALT_INSTRUCTION);

`ifdef IF_BRANCH_FLUSH_EN
    assign w_next_instruction = i_branch_control ? '0 : w_fetched;
`else
    assign w_next_instruction = w_fetched;
`endif

    // Program load only while the pipeline is parked; contents survive reset.
    always_ff @(posedge i_clock) begin
        if (i_write_mem_enable && !i_enable_pipeline) begin
            r_mem[i_addr_mem_write] <= i_data_mem_write;
        end
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            r_pc           <= '0;
            r_instruction  <= '0;
            r_out_adder_pc <= '0;
            r_halt_fetched <= 1'b0;
        end else if (w_advance) begin
            r_out_adder_pc <= w_pc_plus1;
            if (w_is_halt) begin
                // Halt outranks any redirect: PC parks on the halt word.
                r_instruction  <= w_fetched;
                r_halt_fetched <= 1'b1;
            end else begin
                r_instruction <= w_next_instruction;
                r_pc          <= i_branch_control ? i_branch_dir : w_pc_plus1;
            end
        end
    end

    assign o_pc           = r_pc;
    assign o_instruction  = r_instruction;
    assign o_out_adder_pc = r_out_adder_pc;
    assign o_halt_fetched = r_halt_fetched;

endmodule

`default_nettype wire
